// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM states.
package nibble_serial_adder_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4_slice.sv
// Combinational 4-bit adder slice with carry in/out, reused every RUN cycle.
module add4_slice
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    // Zero-extend by one bit so the top bit of the result is the carry out.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: one 4-bit slice per cycle through a single shared adder.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE and out_valid only in DONE; both are
// decoded from the state register, so neither depends combinationally on the
// partner's valid/ready. Operands are captured on the input transfer edge and
// the result is held stable from the first out_valid cycle to the output
// transfer edge, and beyond that until the next acceptance.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = SLICE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         ovf,
    output state_t       fsm_state
);

    localparam int                IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t               state;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic                 carry_q;
    logic [IDX_W-1:0]     idx;

    logic [SLICE_W-1:0]   a_slice;
    logic [SLICE_W-1:0]   b_slice;
    logic [SLICE_W-1:0]   slice_sum;
    logic                 slice_cout;
    logic                 msb_cin;
    logic [W-1:0]         sum_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign fsm_state = state;

    // Select the operand slices addressed by idx from the captured operands.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                a_slice = a_q[i*SLICE_W +: SLICE_W];
                b_slice = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    add4_slice u_slice (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Carry into the top bit of the slice, recovered from its sum bit; on the
    // last slice this is the carry into the MSB used for overflow.
    assign msb_cin = a_slice[SLICE_W-1] ^ b_slice[SLICE_W-1] ^ slice_sum[SLICE_W-1];

    // Merge the current slice result into the running sum.
    always_comb begin
        sum_next = sum;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                sum_next[i*SLICE_W +: SLICE_W] = slice_sum;
            end
        end
    end

    // Control FSM plus datapath registers; reset overrides any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= a;
                        b_q       <= b;
                        carry_q   <= cin;
                        idx       <= '0;
                        sum       <= '0;
                        carry_out <= 1'b0;
                        ovf       <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum     <= sum_next;
                    carry_q <= slice_cout;
                    if (idx == LAST_IDX) begin
                        // idx stays on the last slice rather than wrapping.
                        carry_out <= slice_cout;
                        ovf       <= slice_cout ^ msb_cin;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with NIBBLES=4.
module tb_nibble_serial_adder_ctrl;
    import nibble_serial_adder_ctrl_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         ovf;
    state_t       fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[8];
    logic [W+1:0] exp_q[$];

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .ovf       (ovf),
        .fsm_state (fsm_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Overall time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        n_fail = n_fail + 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Runs one operation starting from a negedge in IDLE; ends on a negedge in IDLE.
    task automatic run_op(input vec_t v, input int hold, input bit noise, input string name);
        int lat;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        in_valid = 1'b1;
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (noise) begin
                in_valid  = 1'b1;
                a         = ~v.a;
                b         = ~v.b;
                cin       = ~v.cin;
                out_ready = 1'b1;
            end
            @(negedge clk);
            lat = lat + 1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(N));
        for (int h = 0; h < hold; h++) begin
            check({name, " hold sum"}, 32'(sum), 32'(v.s));
            check({name, " hold flags"}, {28'd0, out_valid, in_ready, carry_out, ovf},
                  {28'd0, 1'b1, 1'b0, v.co, v.ov});
            @(negedge clk);
        end
        check({name, " sum"}, 32'(sum), 32'(v.s));
        check({name, " carry_out"}, 32'(carry_out), 32'(v.co));
        check({name, " ovf"}, 32'(ovf), 32'(v.ov));
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " post ready/valid"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        check({name, " post held"}, {15'd0, carry_out, ovf, sum}, {15'd0, v.co, v.ov, v.s});
    endtask

    initial begin
        int cnt;
        int acc;
        int got;
        int last;
        logic [W+1:0] e;

        //           a         b         cin   sum       co    ov
        vecs[0] = {16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[1] = {16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = {16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = {16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = {16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = {16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = {16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = {16'h1234, 16'h0FFF, 1'b1, 16'h2234, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset state", 32'(fsm_state), 32'(IDLE));
        check("reset ready/valid", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        check("reset result", {15'd0, carry_out, ovf, sum}, 32'd0);

        // Table-driven vectors, plain handshake.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i], 0, 1'b0, $sformatf("vec%0d", i));
        end

        // Stalled consumer with noise on the inputs during RUN.
        run_op(vecs[7], 3, 1'b1, "stall");

        // Reset in the second RUN cycle discards the partial result.
        a        = 16'h1234;
        b        = 16'h0FFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun rst state", 32'(fsm_state), 32'(IDLE));
        check("midrun rst ready/valid", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        check("midrun rst sum", 32'(sum), 32'd0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) cnt = cnt + 1;
            @(negedge clk);
        end
        check("midrun rst no result", 32'(cnt), 32'd0);
        run_op(vecs[3], 0, 1'b0, "after rst");

        // Back-to-back with both handshakes held high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc  = 0;
        got  = 0;
        last = -1;
        for (int c = 0; c < 60 && got < 3; c++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b unexpected result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("b2b result", {14'd0, carry_out, ovf, sum}, {14'd0, e});
                end
                if (last >= 0) check("b2b spacing", 32'(c - last), 32'(N + 2));
                last = c;
                got  = got + 1;
            end
            if (in_ready) begin
                if (acc < 3) begin
                    a   = vecs[acc + 1].a;
                    b   = vecs[acc + 1].b;
                    cin = vecs[acc + 1].cin;
                    exp_q.push_back({vecs[acc + 1].co, vecs[acc + 1].ov, vecs[acc + 1].s});
                    acc = acc + 1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b result count", 32'(got), 32'd3);
        check("b2b queue empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 The block SHALL take parameter NIBBLES, default 4, which sets the number of 4-bit slices per operand (W = 4*NIBBLES).
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have input in_valid, 1 bit: the operand set is presented.
REQ-005 The block SHALL have output in_ready, 1 bit: the block can accept operands.
REQ-006 The block SHALL have inputs a and b, W bits each: unsigned addends.
REQ-007 The block SHALL have input cin, 1 bit: carry into slice 0.
REQ-008 The block SHALL have output out_valid, 1 bit: a result is available.
REQ-009 The block SHALL have input out_ready, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have output sum, W bits: the result of a+b+cin modulo 2^W.
REQ-011 The block SHALL have output carry_out, 1 bit: carry out of the MSB slice.
REQ-012 The block SHALL have output ovf, 1 bit: two's-complement overflow, equal to carry into the MSB XOR carry_out.

Function
REQ-013 The block SHALL compute the W-bit sum serially, one 4-bit slice per cycle, on one shared 4-bit adder slice.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE, encoded in a registered state variable.
REQ-015 in_ready SHALL be 1 only in IDLE, decoded from the state register with no combinational path from in_valid.
REQ-016 In IDLE, when in_valid=1 the block SHALL, on that edge, capture a, b and cin, load the carry register from cin, clear slice index idx to 0, clear sum, carry_out and ovf to 0, and go to RUN.
REQ-017 In RUN, each cycle SHALL add a[4*idx+3:4*idx] + b[same] + carry register, write the 4-bit result into sum[4*idx+3:4*idx], update the carry register and increment idx.
REQ-018 In RUN, when idx=NIBBLES-1, the block SHALL also latch carry_out and ovf, and go to DONE; idx SHALL NOT wrap within an operation.
REQ-019 out_valid SHALL be 1 only in DONE; the first cycle with out_valid=1 SHALL come exactly NIBBLES cycles after the accepting edge.
REQ-020 In DONE, sum, carry_out and ovf SHALL stay constant until the transfer edge (out_valid=1 and out_ready=1); the block SHALL then return to IDLE.
REQ-021 out_ready=1 before DONE SHALL have no effect; in_valid outside IDLE SHALL be ignored, and the captured operands SHALL NOT change.
REQ-022 After return to IDLE, sum, carry_out and ovf SHALL hold the last result until the next acceptance.
REQ-023 With in_valid=1 and out_ready=1 held high, throughput SHALL be one result every NIBBLES+2 cycles.
REQ-024 NIBBLES=1 SHALL be legal: one RUN cycle.

Reset
REQ-025 With rst=1 at a rising edge, the block SHALL set state to IDLE, idx, the carry register, sum, carry_out and ovf to 0, and out_valid to 0, with in_ready=1 in the following cycle.
REQ-026 Reset SHALL win over every other event, including a mid-RUN or mid-DONE operation; any partial result SHALL be discarded and never presented.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the slice width constant SLICE_W=4.
REQ-028 The 4-bit adder SHALL be a separate sub-module, add4_slice (inputs a, b and cin; outputs sum[3:0] and cout; combinational), instantiated once.
REQ-029 idx SHALL be $clog2(NIBBLES) bits wide, minimum 1 bit.

Verification (NIBBLES=4)
REQ-030 a=0x0000, b=0x0001, cin=0 SHALL give sum=0x0001, carry_out=0 and ovf=0, with out_valid 4 cycles after acceptance.
REQ-031 a=0xFFFF, b=0x0001, cin=0 SHALL give sum=0x0000, carry_out=1 and ovf=0; a=0x7FFF, b=0x0001, cin=0 SHALL give sum=0x8000, carry_out=0 and ovf=1.
REQ-032 a=0x1234, b=0x0FFF, cin=1 with out_ready held low 3 cycles in DONE SHALL give sum=0x2234, carry_out=0, with the outputs stable and in_ready=0 throughout; in_valid pulsed during RUN SHALL be ignored.
REQ-033 rst pulsed in the 2nd RUN cycle SHALL give state IDLE, out_valid=0, sum=0 and in_ready=1 on the next cycle; a following a=0x8000, b=0x8000 SHALL give sum=0x0000, carry_out=1 and ovf=1.
REQ-034 Three back-to-back ops with in_valid=1 and out_ready=1 held high SHALL produce 3 results spaced 6 cycles apart, each correct.
